// File: rtl/rr_arbiter_4_pkg.sv
// Shared types for the 4-way round-robin arbiter.
// Exports the FSM state enum, the requester count and the index type.
package arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] arb_idx_t;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Requester-side bundle of the round-robin arbiter.
// Ports: req (to arbiter), grant/grant_idx/grant_valid/timeout (from arbiter).
interface rr_arbiter_4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  arb_idx_t         grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );

endinterface

// File: rtl/rr_arbiter_4_decoder.sv
// 2-to-4 one-hot decoder with enable; drives the arbiter grant vector.
// Ports: en (enable), a (2-bit index), bcode (one-hot, zero when en=0).
module decoder_2_4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] bcode
);

  assign bcode = en ? (4'b0001 << a) : 4'b0000;

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with bounded grant hold.
// Ports: clk, reset (async high), bus (slave: req in; grant, grant_idx,
//        grant_valid, timeout out).
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 4
) (
  input  logic           clk,
  input  logic           reset,
  rr_arbiter_4_if.slave  bus
);

  arb_state_t     state_q, state_d;
  arb_idx_t       idx_q, idx_d;
  arb_idx_t       last_q, last_d;
  logic [CW-1:0]  hold_q, hold_d;
  logic           to_q, to_d;
  logic           valid;

  logic [2:0]     pick_any;
  logic [2:0]     pick_oth;
  logic           own;
  logic           at_max;

  // First set request scanning ptr+1, ptr+2, ptr+3, ptr; the pointer
  // itself is skipped when excl is set. Result is {found, idx}.
  function automatic logic [2:0] next_rr(
    input logic [N_REQ-1:0] r,
    input arb_idx_t         ptr,
    input logic             excl
  );
    logic [2:0] res;
    arb_idx_t   c;
    res = 3'b000;
    // Walk backwards so the earliest candidate overwrites later ones.
    for (int k = N_REQ; k >= 1; k--) begin
      c = ptr + arb_idx_t'(k);
      if (r[c] && !(excl && k == N_REQ)) begin
        res = {1'b1, c};
      end
    end
    return res;
  endfunction

  // In GRANT last_q always equals the owner, so excluding the pointer
  // excludes the owner.
  assign pick_any = next_rr(bus.req, last_q, 1'b0);
  assign pick_oth = next_rr(bus.req, last_q, 1'b1);
  assign own      = bus.req[idx_q];
  assign at_max   = (hold_q >= CW'(HOLD_MAX));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any[2]) begin
          state_d = GRANT;
          idx_d   = pick_any[1:0];
          last_d  = pick_any[1:0];
          hold_d  = CW'(1);
        end
      end
      GRANT: begin
        unique case (1'b1)
          own && (!pick_oth[2] || !at_max): begin
            hold_d = at_max ? hold_q : hold_q + 1'b1;
          end
          own && pick_oth[2] && at_max: begin
            idx_d  = pick_oth[1:0];
            last_d = pick_oth[1:0];
            hold_d = CW'(1);
            to_d   = 1'b1;
          end
          !own && pick_oth[2]: begin
            idx_d  = pick_oth[1:0];
            last_d = pick_oth[1:0];
            hold_d = CW'(1);
          end
          !own && !pick_oth[2]: begin
            state_d = IDLE;
            hold_d  = '0;
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'b00;
      last_q  <= 2'b11;
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign valid           = (state_q == GRANT);
  assign bus.grant_valid = valid;
  assign bus.grant_idx   = idx_q;
  assign bus.timeout     = to_q;

  decoder_2_4 u_dec (
    .en    (valid),
    .a     (idx_q),
    .bcode (bus.grant)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed cases plus random traffic
// compared every cycle against an owner/pointer reference model.
module tb_rr_arbiter_4;

  localparam int HM = 8;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic chk_on;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(
    .HOLD_MAX (HM),
    .CW       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner (-1 when idle), rotation pointer, hold count.
  int   m_own;
  int   m_last;
  int   m_hold;
  logic m_to;

  function automatic int pick(input int last, input int own,
                              input logic [3:0] r);
    for (int off = 1; off <= 4; off++) begin
      int c;
      c = (last + off) % 4;
      if (c != own && r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    int   n_own;
    int   n_last;
    int   n_hold;
    logic n_to;
    int   nxt;
    logic [3:0] r;
    if (reset) begin
      m_own  <= -1;
      m_last <= 3;
      m_hold <= 0;
      m_to   <= 1'b0;
    end else begin
      r      = bus.req;
      n_own  = m_own;
      n_last = m_last;
      n_hold = m_hold;
      n_to   = 1'b0;
      if (m_own < 0) begin
        nxt = pick(m_last, -1, r);
        if (nxt >= 0) begin
          n_own  = nxt;
          n_last = nxt;
          n_hold = 1;
        end
      end else begin
        nxt = pick(m_last, m_own, r);
        if (r[m_own] && (nxt < 0 || m_hold < HM)) begin
          n_hold = (m_hold < HM) ? m_hold + 1 : HM;
        end else if (nxt >= 0) begin
          n_to   = r[m_own];
          n_own  = nxt;
          n_last = nxt;
          n_hold = 1;
        end else begin
          n_own  = -1;
          n_hold = 0;
        end
      end
      m_own  <= n_own;
      m_last <= n_last;
      m_hold <= n_hold;
      m_to   <= n_to;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] eg;
    if (!reset && chk_on) begin
      eg = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
      chk("m_grant", {28'd0, bus.grant}, {28'd0, eg});
      chk("m_valid", {31'd0, bus.grant_valid}, {31'd0, m_own >= 0});
      if (m_own >= 0)
        chk("m_idx", {30'd0, bus.grant_idx}, 32'(m_own));
      chk("m_timeout", {31'd0, bus.timeout}, {31'd0, m_to});
      chk("onehot", {31'd0, $countones(bus.grant) <= 1}, 32'd1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int hold_left;

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_on      = 1'b0;
    bus.req     = 4'b0000;
    reset       = 1'b1;
    cyc(2);
    reset  = 1'b0;
    chk_on = 1'b1;
    cyc(1);
    chk("rst_grant", {28'd0, bus.grant}, 32'h0);
    chk("rst_valid", {31'd0, bus.grant_valid}, 32'h0);
    chk("rst_idx", {30'd0, bus.grant_idx}, 32'h0);
    chk("rst_timeout", {31'd0, bus.timeout}, 32'h0);

    // single request
    bus.req = 4'b0100;
    cyc(1);
    chk("single_grant", {28'd0, bus.grant}, 32'h4);
    chk("single_idx", {30'd0, bus.grant_idx}, 32'd2);
    chk("model_owner", 32'(m_own), 32'd2);
    bus.req = 4'b0000;
    cyc(1);
    chk("single_drop", {28'd0, bus.grant}, 32'h0);

    // pointer: last owner 2, search 3,0,1,2
    bus.req = 4'b0101;
    cyc(1);
    chk("ptr_grant", {28'd0, bus.grant}, 32'h1);
    bus.req = 4'b1111;
    cyc(1);
    chk("ptr_keep", {28'd0, bus.grant}, 32'h1);

    // asynchronous reset mid-grant
    #2 reset = 1'b1;
    #1;
    chk("arst_grant", {28'd0, bus.grant}, 32'h0);
    chk("arst_valid", {31'd0, bus.grant_valid}, 32'h0);
    chk("arst_timeout", {31'd0, bus.timeout}, 32'h0);
    bus.req = 4'b0000;
    @(negedge clk);
    reset = 1'b0;

    // fairness with all four requesting
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < HM; c++) begin
        cyc(1);
        chk("fair_grant", {28'd0, bus.grant},
            {28'd0, 4'b0001 << (g % 4)});
        chk("fair_timeout", {31'd0, bus.timeout},
            {31'd0, (c == 0 && g > 0)});
      end
    end
    bus.req = 4'b0000;
    cyc(1);

    // owner 1 drops while 3 waits
    bus.req = 4'b0010;
    cyc(1);
    chk("ho_own1", {28'd0, bus.grant}, 32'h2);
    bus.req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("ho_hold", {28'd0, bus.grant}, 32'h2);
    end
    bus.req = 4'b1000;
    cyc(1);
    chk("ho_grant", {28'd0, bus.grant}, 32'h8);
    chk("ho_valid", {31'd0, bus.grant_valid}, 32'h1);
    chk("ho_timeout", {31'd0, bus.timeout}, 32'h0);
    bus.req = 4'b0000;
    cyc(1);

    // solo hold, then saturated counter forces a timed-out handoff
    bus.req = 4'b0010;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      chk("solo_grant", {28'd0, bus.grant}, 32'h2);
      chk("solo_timeout", {31'd0, bus.timeout}, 32'h0);
    end
    bus.req = 4'b0110;
    cyc(1);
    chk("sat_grant", {28'd0, bus.grant}, 32'h4);
    chk("sat_timeout", {31'd0, bus.timeout}, 32'h1);
    cyc(1);
    chk("sat_pulse", {31'd0, bus.timeout}, 32'h0);
    bus.req = 4'b0000;
    cyc(1);

    // random traffic with occasional asynchronous resets
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        bus.req   = 4'($urandom);
        hold_left = $urandom_range(1, 14);
      end
      hold_left--;
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #1;
        chk("rnd_arst", {28'd0, bus.grant}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
      end else begin
        cyc(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
